snake_graphic_renderer: RTL and testbench
=========================================

Name: snake_graphic_renderer

Overview:
- Pixel-level renderer for the Snake game on a 640x480 VGA raster driven by the 25 MHz pixel clock.
- Takes the current scan position (X, Y) from the VGA timing block, plus snake head, body and fruit positions from game logic, on an 8x8-pixel block grid (80x60 blocks).
- Outputs the block and local coordinates, which figure occupies the current block, and a 2-bit colour code for the VGA colour mapper.
- Stores up to 16 body segments, which game logic loads serially.

Parameters:
- PIXEL_DISPLAY_BIT, 9: MSB index of X/Y (X/Y are PIXEL_DISPLAY_BIT+1 bits wide).
- H_ACTIVE, 640: visible pixels per line.
- V_ACTIVE, 480: visible lines per frame.
- MAX_BODY, 16: body segment table depth.

Ports:
- clock_25  input  1  pixel clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- X  input  10  current pixel column (0..799)
- Y  input  10  current pixel line (0..524)
- snake_head_x  input  7  head block column
- snake_head_y  input  7  head block row
- snake_body_x  input  7  body segment column being loaded
- snake_body_y  input  7  body segment row being loaded
- fruit_x  input  7  fruit block column
- fruit_y  input  7  fruit block row
- en_snake_body  input  1  body load strobe
- snake_length  input  4  number of valid body segments (0..15)
- game_enable  output  1  pixel valid, drive colour
- game_data  output  2  colour code
- game_area  output  1  pixel inside visible area
- semaforo  output  1  vertical-blank flag
- selected_figure  output  2  figure at current block
- x_block  output  7  X[9:3]
- y_block  output  7  Y[9:3]
- x_local  output  3  X[2:0]
- y_local  output  3  Y[2:0]

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, body table cleared to (0,0), load index 0.
- All outputs are registered. Every output reflects the X/Y sampled on the previous clock edge (1-cycle latency).
- Block and local coordinates: x_block = X[9:3], x_local = X[2:0]; y_block and y_local are derived from Y the same way.
- game_area = (X < H_ACTIVE) && (Y < V_ACTIVE).
- game_enable = game_area.
- semaforo = (Y >= V_ACTIVE), marking the safe window for game logic to update positions.
- Body load:
  - On each edge with en_snake_body=1, write (snake_body_x, snake_body_y) to table[index], then increment index.
  - The index saturates at MAX_BODY-1; further writes overwrite the last entry.
  - On any edge with en_snake_body=0, index returns to 0. Table contents are retained.
- Figure selection: compare the block coordinates with the positions, using priority head > body > fruit > background.
  - Head match: selected_figure = 01.
  - Body match: table[i] equals the block for some i < snake_length. selected_figure = 10. Entries at i >= snake_length are ignored.
  - Fruit match: selected_figure = 11.
  - Otherwise: selected_figure = 00.
- game_data (colour codes: 00 black, 01 green, 10 red, 11 white):
  - Outside game_area: 00, and selected_figure is forced to 00.
  - Head: 01, except local pixels (5,2) and (5,5), which are 11 (eyes).
  - Body: 01, except x_local==0 or y_local==0, which are 00 (segment gap).
  - Fruit: 10, except the four corner pixels (0,0), (0,7), (7,0) and (7,7), which are 00.
  - Background: 00.
- Block coordinates outside the 0..79 / 0..59 range never match, because X/Y there are outside game_area.
- Reset mid-frame clears the body table, so no body segments are drawn until game logic reloads them.

Optional Feature:
- BORDER_EN defined: blocks with x_block==0, x_block==79, y_block==0 or y_block==59 render game_data=11 with selected_figure=00. The border overrides head, body and fruit.
- BORDER_EN undefined: no border; those blocks render normally.

Test Plan:
- Reset asserted mid-line: all outputs 0 immediately, without waiting for a clock edge. After release, X=10, Y=20 gives x_block=1, x_local=2, y_block=2, y_local=4 one cycle later.
- Head at (2,2), X=21, Y=18 (local 5,2): selected_figure=01, game_data=11. X=19, Y=19: game_data=01.
- Body load, then draw:
  - Load with en_snake_body=1 for 2 cycles, first (8,8) then (1,1). Set snake_length=2.
  - Block (8,8), local (3,3): selected_figure=10, game_data=01.
  - Block (1,1), local (0,4): game_data=00.
  - With snake_length=1, block (1,1) renders background.
- Fruit at (4,4): pixel (32,32) gives game_data=00 (corner); pixel (35,35) gives selected_figure=11, game_data=10.
- Priority and blanking:
  - Head and fruit both at (4,4): selected_figure=01.
  - X=700, Y=100: game_area=0, game_enable=0, game_data=00.
  - Y=490: semaforo=1.
- BORDER_EN defined: X=3, Y=100 gives game_data=11. X=636, Y=200 gives game_data=11.

Source files
------------

// File: rtl/snake_graphic_renderer.sv
// snake_graphic_renderer
//   Pixel renderer for Snake on a 640x480 raster, 8x8-pixel blocks (80x60).
//   Every output is registered and reflects the X/Y seen on the previous
//   clock edge.
//
// Ports
//   clock_25        in   pixel clock, rising edge
//   reset           in   asynchronous active-high reset
//   X, Y            in   current scan position
//   snake_head_x/y  in   head block coordinates
//   snake_body_x/y  in   body segment being loaded
//   fruit_x/y       in   fruit block coordinates
//   en_snake_body   in   body load strobe (one segment per cycle)
//   snake_length    in   number of valid body segments
//   game_enable     out  pixel valid: game_data is meaningful when high
//   game_data       out  colour code (00 black, 01 green, 10 red, 11 white)
//   game_area       out  pixel inside the visible area
//   semaforo        out  vertical blank: safe window to update positions
//   selected_figure out  00 background, 01 head, 10 body, 11 fruit
//   x_block/y_block out  block coordinates
//   x_local/y_local out  pixel position inside the block
//
// Build option
//   BORDER_EN : when defined, the outermost ring of blocks draws a white
//               border that overrides every figure.
//
// Output timing: there is no backpressure. game_enable acts as a valid
// strobe for the colour sampled that cycle; the consumer must take it.

module snake_graphic_renderer #(
    parameter int PIXEL_DISPLAY_BIT = 9,
    parameter int H_ACTIVE          = 640,
    parameter int V_ACTIVE          = 480,
    parameter int MAX_BODY          = 16
) (
    input  logic                       clock_25,
    input  logic                       reset,
    input  logic [PIXEL_DISPLAY_BIT:0] X,
    input  logic [PIXEL_DISPLAY_BIT:0] Y,
    input  logic [6:0]                 snake_head_x,
    input  logic [6:0]                 snake_head_y,
    input  logic [6:0]                 snake_body_x,
    input  logic [6:0]                 snake_body_y,
    input  logic [6:0]                 fruit_x,
    input  logic [6:0]                 fruit_y,
    input  logic                       en_snake_body,
    input  logic [3:0]                 snake_length,
    output logic                       game_enable,
    output logic [1:0]                 game_data,
    output logic                       game_area,
    output logic                       semaforo,
    output logic [1:0]                 selected_figure,
    output logic [6:0]                 x_block,
    output logic [6:0]                 y_block,
    output logic [2:0]                 x_local,
    output logic [2:0]                 y_local
);

    localparam int PW    = PIXEL_DISPLAY_BIT + 1;
    localparam int IDX_W = $clog2(MAX_BODY);
    localparam logic [PW-1:0]    H_LIM    = PW'(H_ACTIVE);
    localparam logic [PW-1:0]    V_LIM    = PW'(V_ACTIVE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_BODY - 1);

    logic [6:0]       body_x [MAX_BODY];
    logic [6:0]       body_y [MAX_BODY];
    logic [IDX_W-1:0] load_idx;

    // Combinational view of the current scan position
    logic [6:0] xb_n, yb_n;
    logic [2:0] xl_n, yl_n;
    logic       area_n, sem_n;
    logic       head_hit, body_hit, fruit_hit;
    logic [1:0] fig_n, data_n;

    assign xb_n   = X[PIXEL_DISPLAY_BIT:3];
    assign yb_n   = Y[PIXEL_DISPLAY_BIT:3];
    assign xl_n   = X[2:0];
    assign yl_n   = Y[2:0];
    assign area_n = (X < H_LIM) && (Y < V_LIM);
    assign sem_n  = (Y >= V_LIM);

    assign head_hit  = (xb_n == snake_head_x) && (yb_n == snake_head_y);
    assign fruit_hit = (xb_n == fruit_x) && (yb_n == fruit_y);

    // Only the first snake_length entries are live; stale entries beyond
    // that are kept in the table but never drawn.
    always_comb begin
        body_hit = 1'b0;
        for (int i = 0; i < MAX_BODY; i++) begin
            if ((i < int'(snake_length)) && (body_x[i] == xb_n) && (body_y[i] == yb_n))
                body_hit = 1'b1;
        end
    end

`ifdef BORDER_EN
    logic border_hit;
    assign border_hit = (xb_n == 7'd0) || (xb_n == 7'(H_ACTIVE / 8 - 1)) ||
                        (yb_n == 7'd0) || (yb_n == 7'(V_ACTIVE / 8 - 1));
`endif

    always_comb begin
        fig_n  = 2'b00;
        data_n = 2'b00;
        if (area_n) begin
            if (head_hit) begin
                fig_n  = 2'b01;
                // eyes
                data_n = (xl_n == 3'd5 && (yl_n == 3'd2 || yl_n == 3'd5)) ? 2'b11 : 2'b01;
            end else if (body_hit) begin
                fig_n  = 2'b10;
                // one-pixel gap on the top/left edge separates segments
                data_n = (xl_n == 3'd0 || yl_n == 3'd0) ? 2'b00 : 2'b01;
            end else if (fruit_hit) begin
                fig_n  = 2'b11;
                // rounded corners
                data_n = ((xl_n == 3'd0 || xl_n == 3'd7) && (yl_n == 3'd0 || yl_n == 3'd7)) ? 2'b00 : 2'b10;
            end
`ifdef BORDER_EN
            if (border_hit) begin
                fig_n  = 2'b00;
                data_n = 2'b11;
            end
`endif
        end
    end

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            game_enable     <= 1'b0;
            game_data       <= 2'b00;
            game_area       <= 1'b0;
            semaforo        <= 1'b0;
            selected_figure <= 2'b00;
            x_block         <= 7'd0;
            y_block         <= 7'd0;
            x_local         <= 3'd0;
            y_local         <= 3'd0;
            load_idx        <= '0;
            for (int i = 0; i < MAX_BODY; i++) begin
                body_x[i] <= 7'd0;
                body_y[i] <= 7'd0;
            end
        end else begin
            game_enable     <= area_n;
            game_data       <= data_n;
            game_area       <= area_n;
            semaforo        <= sem_n;
            selected_figure <= fig_n;
            x_block         <= xb_n;
            y_block         <= yb_n;
            x_local         <= xl_n;
            y_local         <= yl_n;
            // Serial load: index runs while the strobe is held and restarts
            // from 0 as soon as it drops; past the end it keeps rewriting
            // the last entry.
            if (en_snake_body) begin
                body_x[load_idx] <= snake_body_x;
                body_y[load_idx] <= snake_body_y;
                if (load_idx != IDX_LAST)
                    load_idx <= load_idx + 1'b1;
            end else begin
                load_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_snake_graphic_renderer.sv
// Self-checking bench for snake_graphic_renderer: directed cases followed by
// randomized traffic, checked against an arithmetic model of the renderer.
module tb_snake_graphic_renderer;

    localparam int W = 27;

    logic       clock_25 = 1'b0;
    logic       reset;
    logic [9:0] X, Y;
    logic [6:0] snake_head_x, snake_head_y, snake_body_x, snake_body_y;
    logic [6:0] fruit_x, fruit_y;
    logic       en_snake_body;
    logic [3:0] snake_length;
    logic       game_enable, game_area, semaforo;
    logic [1:0] game_data, selected_figure;
    logic [6:0] x_block, y_block;
    logic [2:0] x_local, y_local;

    snake_graphic_renderer dut (
        .clock_25(clock_25), .reset(reset), .X(X), .Y(Y),
        .snake_head_x(snake_head_x), .snake_head_y(snake_head_y),
        .snake_body_x(snake_body_x), .snake_body_y(snake_body_y),
        .fruit_x(fruit_x), .fruit_y(fruit_y),
        .en_snake_body(en_snake_body), .snake_length(snake_length),
        .game_enable(game_enable), .game_data(game_data), .game_area(game_area),
        .semaforo(semaforo), .selected_figure(selected_figure),
        .x_block(x_block), .y_block(y_block), .x_local(x_local), .y_local(y_local)
    );

    // ---------------- clock ----------------
    always #20 clock_25 = ~clock_25;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    string        name_q[$];

    // ---------------- reference model ----------------
    int m_bx[16], m_by[16];
    int m_idx;
    // values applied on the next drive
    int n_hx, n_hy, n_fx, n_fy, n_len;

    function automatic logic [W-1:0] model(int x, int y);
        int  xb, yb, xl, yl, fig, data;
        bit  area, sem, body;
        xb = x / 8; yb = y / 8; xl = x % 8; yl = y % 8;
        area = (x < 640) && (y < 480);
        sem  = (y >= 480);
        body = 0;
        for (int i = 0; i < n_len; i++)
            if (m_bx[i] == xb && m_by[i] == yb) body = 1;
        fig = 0; data = 0;
        if (area) begin
            if (xb == n_hx && yb == n_hy) begin
                fig = 1; data = (xl == 5 && (yl == 2 || yl == 5)) ? 3 : 1;
            end else if (body) begin
                fig = 2; data = (xl == 0 || yl == 0) ? 0 : 1;
            end else if (xb == n_fx && yb == n_fy) begin
                fig = 3; data = ((xl == 0 || xl == 7) && (yl == 0 || yl == 7)) ? 0 : 2;
            end
`ifdef BORDER_EN
            if (xb == 0 || xb == 79 || yb == 0 || yb == 59) begin
                fig = 0; data = 3;
            end
`endif
        end
        return {area, 2'(data), area, sem, 2'(fig), 7'(xb), 7'(yb), 3'(xl), 3'(yl)};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin m_bx[i] = 0; m_by[i] = 0; end
        m_idx = 0;
    endtask

    // ---------------- driver ----------------
    task automatic drive(string name, int x, int y, bit en = 0, int bx = 0, int by = 0);
        @(negedge clock_25);
        X = 10'(x); Y = 10'(y);
        en_snake_body = en; snake_body_x = 7'(bx); snake_body_y = 7'(by);
        snake_head_x = 7'(n_hx); snake_head_y = 7'(n_hy);
        fruit_x = 7'(n_fx); fruit_y = 7'(n_fy); snake_length = 4'(n_len);
        exp_q.push_back(model(x, y));
        name_q.push_back(name);
        // table update happens after the figure lookup of this same edge
        if (en) begin
            m_bx[m_idx] = bx; m_by[m_idx] = by;
            if (m_idx < 15) m_idx++;
        end else begin
            m_idx = 0;
        end
    endtask

    function automatic logic [W-1:0] got_vec();
        return {game_enable, game_data, game_area, semaforo, selected_figure,
                x_block, y_block, x_local, y_local};
    endfunction

    task automatic check_zero(string name);
        checks++;
        if (got_vec() !== '0) begin
            errors++;
            $display("FAIL %s outputs=%h required=0", name, got_vec());
        end
    endtask

    // ---------------- monitor ----------------
    always begin
        @(posedge clock_25);
        #1;
        if (!reset && exp_q.size() > 0) begin
            logic [W-1:0] e;
            string        n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (got_vec() !== e) begin
                errors++;
                $display("FAIL %s got=%h (data=%0d fig=%0d) required=%h (data=%0d fig=%0d)",
                         n, got_vec(), game_data, selected_figure, e, e[25:24], e[21:20]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        X = '0; Y = '0; en_snake_body = 0; snake_body_x = '0; snake_body_y = '0;
        snake_head_x = '0; snake_head_y = '0; fruit_x = '0; fruit_y = '0; snake_length = '0;
        n_hx = 70; n_hy = 50; n_fx = 70; n_fy = 51; n_len = 0;
        model_clear();
        #5;
        check_zero("reset_initial");
        @(negedge clock_25);
        reset = 1'b0;

        drive("coords_10_20", 10, 20);

        n_hx = 2; n_hy = 2;
        drive("head_eye", 21, 18);
        drive("head_green", 19, 19);

        n_hx = 70; n_hy = 50;
        drive("load_0", 300, 300, 1, 8, 8);
        drive("load_1", 300, 300, 1, 1, 1);
        n_len = 2;
        drive("body_8_8", 67, 67);
        drive("body_gap", 8, 12);
        drive("body_1_1", 11, 11);
        n_len = 1;
        drive("body_len_cut", 11, 11);

        n_fx = 4; n_fy = 4;
        drive("fruit_corner", 32, 32);
        drive("fruit_red", 35, 35);
        n_hx = 4; n_hy = 4;
        drive("head_over_fruit", 35, 35);

        drive("hblank", 700, 100);
        drive("vblank", 100, 490);
        drive("border_left", 3, 100);
        drive("border_right", 636, 200);

        // index saturation: 18 writes, the last three all land in entry 15
        n_hx = 70; n_hy = 50; n_fx = 70; n_fy = 51;
        for (int i = 0; i < 18; i++)
            drive("sat_load", 500, 500, 1, 20 + i, 30);
        n_len = 15;
        for (int i = 0; i < 16; i++)
            drive("sat_draw", (20 + i) * 8 + 3, 30 * 8 + 3);
        // strobe dropped: next load starts again at entry 0
        drive("reload", 500, 500, 1, 5, 6);
        drive("reload_draw", 5 * 8 + 4, 6 * 8 + 4);

        // mid-line asynchronous reset
        @(posedge clock_25);
        #5;
        reset = 1'b1;
        #1;
        check_zero("reset_async");
        exp_q.delete(); name_q.delete();
        model_clear();
        @(negedge clock_25);
        @(negedge clock_25);
        reset = 1'b0;
        drive("after_reset", 10, 20);
        n_len = 1;
        drive("table_cleared", 5 * 8 + 4, 6 * 8 + 4);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            int x, y, bx, by;
            bit en;
            if ($urandom_range(0, 9) == 0) begin n_hx = $urandom_range(0, 15); n_hy = $urandom_range(0, 15); end
            if ($urandom_range(0, 9) == 0) begin n_fx = $urandom_range(0, 15); n_fy = $urandom_range(0, 15); end
            if ($urandom_range(0, 19) == 0) n_len = $urandom_range(0, 15);
            en = ($urandom_range(0, 3) == 0);
            bx = $urandom_range(0, 15); by = $urandom_range(0, 15);
            x = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 127) : $urandom_range(0, 799);
            y = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 127) : $urandom_range(0, 524);
            drive("random", x, y, en, bx, by);
        end
        drive("idle", 0, 0);

        @(posedge clock_25);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
